// File: rtl/unpremuat_16_ser_pkg.sv
// rtl/unpremuat_16_ser_pkg.sv - coefficient width, vector length and 16-point permutation map
package unpremuat_16_ser_pkg;

    localparam int DW = 28;
    localparam int N  = 16;

    // Natural index n -> position in the permuted vector. Forward is a 4-bit
    // rotate-left (even/odd split); inverse is the matching rotate-right.
    function automatic logic [3:0] src_idx(
        input logic [3:0] n,
        input logic       enable,
        input logic       inverse
    );
        logic [3:0] s;
        if (!enable) begin
            s = n;
        end else if (!inverse) begin
            s = {n[2:0], n[3]};
        end else begin
            s = {n[0], n[3:1]};
        end
        return s;
    endfunction

endpackage

// File: rtl/unpremuat_16_bank.sv
// rtl/unpremuat_16_bank.sv - one 16-coefficient vector buffer with its latched mode and full flag
module unpremuat_16_bank
    import unpremuat_16_ser_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [N*DW-1:0]   data,
    input  logic              enable,
    input  logic              inverse,
    input  logic [3:0]        sel,
    output logic              full,
    output logic              enable_q,
    output logic              inverse_q,
    output logic [DW-1:0]     rdata
);

    logic [DW-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= 1'b0;
            enable_q  <= 1'b0;
            inverse_q <= 1'b0;
        end else if (load) begin
            full      <= 1'b1;
            enable_q  <= enable;
            inverse_q <= inverse;
        end else if (clear) begin
            full      <= 1'b0;
        end
    end

    // Storage is left unreset: it is only observed while full is set.
    always_ff @(posedge clk) begin
        if (load && !rst) begin
            for (int k = 0; k < N; k++) begin
                mem[k] <= data[k*DW +: DW];
            end
        end
    end

    assign rdata = mem[sel];

endmodule

// File: rtl/unpremuat_16_ser.sv
// rtl/unpremuat_16_ser.sv - undo 16-point permutation and stream coefficients one per cycle
module unpremuat_16_ser
    import unpremuat_16_ser_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic                 i_enable,
    input  logic                 i_inverse,
    input  logic [N*DW-1:0]      i_data,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic signed [DW-1:0] o_data,
    output logic [3:0]           o_idx,
    output logic                 o_last
);

    logic          wr_ptr;
    logic          rd_ptr;
    logic [3:0]    cnt;
    logic [1:0]    full;
    logic [1:0]    en_q;
    logic [1:0]    inv_q;
    logic [1:0]    load;
    logic [1:0]    clear;
    logic [DW-1:0] rdata [2];
    logic [3:0]    sel   [2];
    logic          in_fire;
    logic          out_fire;
    logic          last_fire;

    assign i_ready   = !full[wr_ptr];
    assign in_fire   = i_valid && i_ready && !rst;
    assign o_valid   = full[rd_ptr];
    assign out_fire  = o_valid && o_ready;
    assign last_fire = out_fire && (cnt == 4'(N - 1));

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            assign load[b]  = in_fire && (wr_ptr == 1'(b));
            assign clear[b] = last_fire && (rd_ptr == 1'(b));
            assign sel[b]   = src_idx(cnt, en_q[b], inv_q[b]);

            unpremuat_16_bank u_bank (
                .clk       (clk),
                .rst       (rst),
                .load      (load[b]),
                .clear     (clear[b]),
                .data      (i_data),
                .enable    (i_enable),
                .inverse   (i_inverse),
                .sel       (sel[b]),
                .full      (full[b]),
                .enable_q  (en_q[b]),
                .inverse_q (inv_q[b]),
                .rdata     (rdata[b])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 4'd0;
        end else begin
            if (in_fire) begin
                wr_ptr <= !wr_ptr;
            end
            if (out_fire) begin
                cnt <= cnt + 4'd1;
            end
            if (last_fire) begin
                rd_ptr <= !rd_ptr;
            end
        end
    end

    // Outputs are forced to zero whenever no beat is being offered.
    always_comb begin
        o_data = '0;
        o_idx  = 4'd0;
        o_last = 1'b0;
        if (o_valid) begin
            o_data = rdata[rd_ptr];
            o_idx  = cnt;
            o_last = (cnt == 4'(N - 1));
        end
    end

endmodule

// File: tb/tb_unpremuat_16_ser.sv
// tb/tb_unpremuat_16_ser.sv - self-checking bench for unpremuat_16_ser
module tb_unpremuat_16_ser;
    import unpremuat_16_ser_pkg::*;

    typedef struct packed {
        logic                 en;
        logic                 inv;
        logic [15:0][DW-1:0]  y;
    } vec_t;

    typedef struct packed {
        logic            en;
        logic            inv;
        logic [0:15][7:0] exp;
    } row_t;

    logic                 clk;
    logic                 rst;
    logic                 i_valid;
    logic                 i_ready;
    logic                 i_enable;
    logic                 i_inverse;
    logic [16*DW-1:0]     i_data;
    logic                 o_valid;
    logic                 o_ready;
    logic signed [DW-1:0] o_data;
    logic [3:0]           o_idx;
    logic                 o_last;

    unpremuat_16_ser dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_enable  (i_enable),
        .i_inverse (i_inverse),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_idx     (o_idx),
        .o_last    (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    vec_t          cur;
    vec_t          mq[$];
    int            mn = 0;
    bit            model_ok = 0;
    logic [DW-1:0] cap[$];
    int            cap_cyc[$];
    int            acc_cyc[$];
    int            last_cyc[$];
    row_t          rows [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int ref_src(input int n, input bit en, input bit inv);
        if (!en) return n;
        if (!inv) return (n < 8) ? 2 * n : 2 * (n - 8) + 1;
        return (n % 2 == 0) ? n / 2 : (n - 1) / 2 + 8;
    endfunction

    function automatic vec_t mk_vec(input bit en, input bit inv, input bit rnd);
        vec_t v;
        v.en  = en;
        v.inv = inv;
        for (int k = 0; k < 16; k++) begin
            v.y[k] = rnd ? DW'($urandom) : DW'(100 + k);
        end
        return v;
    endfunction

    task automatic set_cur(input vec_t v);
        cur       = v;
        i_enable  = v.en;
        i_inverse = v.inv;
        for (int k = 0; k < 16; k++) begin
            i_data[k*DW +: DW] = v.y[k];
        end
    endtask

    // One clock: compare against the queue model at the falling edge, then
    // advance the model at the rising edge using the same handshakes.
    task automatic tick();
        bit            ev, er, inf, outf;
        logic [DW-1:0] ed;
        int            ei;
        @(negedge clk);
        ev = mq.size() > 0;
        er = mq.size() < 2;
        ed = '0;
        ei = 0;
        if (ev) begin
            ei = mn;
            ed = mq[0].y[ref_src(mn, mq[0].en, mq[0].inv)];
        end
        if (model_ok) begin
            check("o_valid", 32'(o_valid), 32'(ev));
            check("i_ready", 32'(i_ready), 32'(er));
            check("o_idx", 32'(o_idx), 32'(ei));
            check("o_last", 32'(o_last), 32'(ev && ei == 15));
            check("o_data", 32'($unsigned(o_data)), 32'(ed));
        end
        if (o_valid && o_ready) begin
            cap.push_back(o_data);
            cap_cyc.push_back(cyc);
            if (o_last) last_cyc.push_back(cyc);
        end
        if (i_valid && i_ready && !rst) acc_cyc.push_back(cyc);
        inf  = i_valid && er && !rst;
        outf = ev && o_ready;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mn       = 0;
            model_ok = 1;
        end else begin
            if (outf) begin
                if (mn == 15) begin
                    void'(mq.pop_front());
                    mn = 0;
                end else begin
                    mn++;
                end
            end
            if (inf) mq.push_back(cur);
        end
        cyc++;
        #1;
    endtask

    initial begin
        rows[0].en = 1'b0; rows[0].inv = 1'b0;
        rows[0].exp = '{8'd100, 8'd101, 8'd102, 8'd103, 8'd104, 8'd105, 8'd106, 8'd107,
                        8'd108, 8'd109, 8'd110, 8'd111, 8'd112, 8'd113, 8'd114, 8'd115};
        rows[1].en = 1'b1; rows[1].inv = 1'b0;
        rows[1].exp = '{8'd100, 8'd102, 8'd104, 8'd106, 8'd108, 8'd110, 8'd112, 8'd114,
                        8'd101, 8'd103, 8'd105, 8'd107, 8'd109, 8'd111, 8'd113, 8'd115};
        rows[2].en = 1'b1; rows[2].inv = 1'b1;
        rows[2].exp = '{8'd100, 8'd108, 8'd101, 8'd109, 8'd102, 8'd110, 8'd103, 8'd111,
                        8'd104, 8'd112, 8'd105, 8'd113, 8'd106, 8'd114, 8'd107, 8'd115};

        rst     = 1'b1;
        i_valid = 1'b0;
        o_ready = 1'b0;
        i_data  = '0;
        set_cur(mk_vec(0, 0, 0));
        tick();
        tick();
        rst = 1'b0;
        check("reset_o_valid", 32'(o_valid), 32'd0);
        check("reset_o_data", 32'($unsigned(o_data)), 32'd0);
        check("reset_o_idx", 32'(o_idx), 32'd0);
        check("reset_o_last", 32'(o_last), 32'd0);
        check("reset_i_ready", 32'(i_ready), 32'd1);

        // Single vectors in each mode against fixed expected sequences.
        for (int r = 0; r < 3; r++) begin
            cap.delete();
            set_cur(mk_vec(rows[r].en, rows[r].inv, 0));
            i_valid = 1'b1;
            o_ready = 1'b1;
            tick();
            i_valid = 1'b0;
            check("latency_o_valid", 32'(o_valid), 32'd1);
            check("latency_o_idx", 32'(o_idx), 32'd0);
            repeat (17) tick();
            check("row_beats", 32'(cap.size()), 32'd16);
            for (int k = 0; k < 16; k++) begin
                if (k < cap.size()) check("row_data", 32'(cap[k]), 32'(rows[r].exp[k]));
            end
        end

        // Three vectors offered continuously.
        cap.delete(); cap_cyc.delete(); acc_cyc.delete(); last_cyc.delete();
        i_valid = 1'b1;
        o_ready = 1'b1;
        for (int c = 0; c < 70; c++) begin
            if (acc_cyc.size() >= 3) i_valid = 1'b0;
            else set_cur(mk_vec(1'($urandom), 1'($urandom), 0));
            tick();
        end
        i_valid = 1'b0;
        check("b2b_accepts", 32'(acc_cyc.size()), 32'd3);
        check("b2b_beats", 32'(cap.size()), 32'd48);
        if (acc_cyc.size() == 3 && last_cyc.size() >= 1) begin
            check("b2b_second_accept", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
            check("b2b_third_accept", 32'(acc_cyc[2]), 32'(last_cyc[0] + 1));
        end else begin
            check("b2b_accept_cycles", 32'(acc_cyc.size()), 32'd99);
        end
        if (cap_cyc.size() == 48) begin
            check("b2b_no_gap", 32'(cap_cyc[47] - cap_cyc[0]), 32'd47);
            check("b2b_first_beat", 32'(cap_cyc[0]), 32'(acc_cyc[0] + 1));
        end

        // Backpressure at o_idx = 3.
        set_cur(mk_vec(0, 0, 0));
        i_valid = 1'b1;
        o_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        repeat (3) tick();
        o_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("hold_o_data", 32'($unsigned(o_data)), 32'd103);
            check("hold_o_idx", 32'(o_idx), 32'd3);
            tick();
        end
        cap.delete();
        o_ready = 1'b1;
        repeat (14) tick();
        check("resume_beats", 32'(cap.size()), 32'd13);
        if (cap.size() >= 2) begin
            check("resume_first", 32'(cap[0]), 32'd103);
            check("resume_second", 32'(cap[1]), 32'd104);
        end

        // Reset mid-drain with the second bank full.
        set_cur(mk_vec(0, 0, 0));
        i_valid = 1'b1;
        tick();
        set_cur(mk_vec(1, 0, 0));
        tick();
        i_valid = 1'b0;
        repeat (5) tick();
        check("pre_rst_idx", 32'(o_idx), 32'd6);
        check("pre_rst_ready", 32'(i_ready), 32'd0);
        rst = 1'b1;
        set_cur(mk_vec(1, 1, 1));
        i_valid = 1'b1;
        tick();
        rst = 1'b0;
        i_valid = 1'b0;
        check("post_rst_o_valid", 32'(o_valid), 32'd0);
        check("post_rst_o_data", 32'($unsigned(o_data)), 32'd0);
        check("post_rst_i_ready", 32'(i_ready), 32'd1);
        cap.delete();
        set_cur(mk_vec(0, 0, 0));
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        repeat (17) tick();
        check("post_rst_beats", 32'(cap.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            if (k < cap.size()) check("post_rst_data", 32'(cap[k]), 32'(100 + k));
        end

        // Random traffic, modes, data and occasional reset.
        for (int c = 0; c < 800; c++) begin
            set_cur(mk_vec(1'($urandom), 1'($urandom), 1));
            i_valid = ($urandom_range(0, 9) < 7);
            o_ready = ($urandom_range(0, 9) < 7);
            rst     = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b1;
        repeat (40) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
